// File: rtl/monkey_collision_ctrl.sv
// Monkey collision controller: checks the monkey drawing request against each
// target layer, emits first-overlap pulses, reports per-frame OR-ed hit edges
// and keeps a hysteresis-filtered contact flag per target.
// Build option: define COLLISION_PRIORITY_EN to let only the lowest-index
// overlapping target register a hit in any given cycle.
//
// state | meaning
// IDLE  | game stopped, all outputs and internal state held at zero
// SYNC  | enabled, waiting for the first startOfFrame to align to a frame
// RUN   | tracking overlaps and reporting at every frame boundary
module monkey_collision_ctrl #(
  parameter int NUM_TARGETS = 3,
  parameter int MISS_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       enable,
  input  logic                       startOfFrame,
  input  logic                       monkeyDR,
  input  logic [3:0]                 monkeyHitEdge,
  input  logic [NUM_TARGETS-1:0]     targetDR,
  output logic [NUM_TARGETS-1:0]     collisionPulse,
  output logic [4*NUM_TARGETS-1:0]   frameHitEdge,
  output logic                       frameValid,
  output logic [NUM_TARGETS-1:0]     contact
);

  localparam int MW = $clog2(MISS_FRAMES + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_FRAMES);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t state, state_nxt;

  logic [NUM_TARGETS-1:0]   raw_overlap, overlap;
  logic [4*NUM_TARGETS-1:0] acc, acc_nxt;
  logic [NUM_TARGETS-1:0]   first_hit, first_nxt;
  logic [MW-1:0]            miss_cnt [NUM_TARGETS];
  logic [MW-1:0]            miss_nxt [NUM_TARGETS];
  logic [NUM_TARGETS-1:0]   pulse_nxt, contact_nxt;
  logic [4*NUM_TARGETS-1:0] fhe_nxt;
  logic                     valid_nxt;

  assign raw_overlap = {NUM_TARGETS{monkeyDR}} & targetDR;

`ifdef COLLISION_PRIORITY_EN
  // isolate the lowest set bit so only one target sees the hit
  assign overlap = raw_overlap & (~raw_overlap + NUM_TARGETS'(1));
`else
  assign overlap = raw_overlap;
`endif

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state: dropping enable always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SYNC;
        SYNC:    if (startOfFrame) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // output / datapath next values
  always_comb begin
    acc_nxt     = acc;
    first_nxt   = first_hit;
    miss_nxt    = miss_cnt;
    contact_nxt = contact;
    fhe_nxt     = frameHitEdge;
    pulse_nxt   = '0;
    valid_nxt   = 1'b0;
    if (!enable || state == IDLE) begin
      acc_nxt     = '0;
      first_nxt   = '0;
      contact_nxt = '0;
      fhe_nxt     = '0;
      for (int i = 0; i < NUM_TARGETS; i++) miss_nxt[i] = '0;
    end else if (state == SYNC) begin
      // alignment frame start: open a fresh frame but report nothing
      if (startOfFrame) begin
        first_nxt = overlap;
        pulse_nxt = overlap;
        for (int i = 0; i < NUM_TARGETS; i++)
          acc_nxt[4*i +: 4] = overlap[i] ? monkeyHitEdge : 4'h0;
      end
    end else if (startOfFrame) begin
      // frame boundary: report the closed frame, the current pixel opens the new one
      valid_nxt = 1'b1;
      fhe_nxt   = acc;
      first_nxt = overlap;
      pulse_nxt = overlap;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        acc_nxt[4*i +: 4] = overlap[i] ? monkeyHitEdge : 4'h0;
        if (acc[4*i +: 4] != 4'h0 || first_hit[i]) begin
          contact_nxt[i] = 1'b1;
          miss_nxt[i]    = '0;
        end else begin
          if (miss_cnt[i] != MISS_MAX) miss_nxt[i] = miss_cnt[i] + MW'(1);
          if (miss_nxt[i] == MISS_MAX) contact_nxt[i] = 1'b0;
        end
      end
    end else begin
      pulse_nxt = overlap & ~first_hit;
      first_nxt = first_hit | overlap;
      for (int i = 0; i < NUM_TARGETS; i++)
        if (overlap[i]) acc_nxt[4*i +: 4] = acc[4*i +: 4] | monkeyHitEdge;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc            <= '0;
      first_hit      <= '0;
      contact        <= '0;
      frameHitEdge   <= '0;
      collisionPulse <= '0;
      frameValid     <= 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) miss_cnt[i] <= '0;
    end else begin
      acc            <= acc_nxt;
      first_hit      <= first_nxt;
      contact        <= contact_nxt;
      frameHitEdge   <= fhe_nxt;
      collisionPulse <= pulse_nxt;
      frameValid     <= valid_nxt;
      for (int i = 0; i < NUM_TARGETS; i++) miss_cnt[i] <= miss_nxt[i];
    end
  end

endmodule

// File: tb/tb_monkey_collision_ctrl.sv
// Directed bench for monkey_collision_ctrl (NUM_TARGETS=3, MISS_FRAMES=2).
module tb_monkey_collision_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic        startOfFrame;
  logic        monkeyDR;
  logic [3:0]  monkeyHitEdge;
  logic [2:0]  targetDR;
  logic [2:0]  collisionPulse;
  logic [11:0] frameHitEdge;
  logic        frameValid;
  logic [2:0]  contact;

  int checks = 0;
  int failures = 0;
  int pulse_sum;

  monkey_collision_ctrl #(.NUM_TARGETS(3), .MISS_FRAMES(2)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
    .monkeyDR(monkeyDR), .monkeyHitEdge(monkeyHitEdge), .targetDR(targetDR),
    .collisionPulse(collisionPulse), .frameHitEdge(frameHitEdge),
    .frameValid(frameValid), .contact(contact)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of inputs, then advance past the edge that samples them
  task automatic step(input logic [2:0] t, input logic [3:0] e, input logic s);
    monkeyDR      = (t != 3'b000);
    targetDR      = t;
    monkeyHitEdge = e;
    startOfFrame  = s;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"}, 32'(collisionPulse), 32'h0);
    chk({tag, "_fhe"},   32'(frameHitEdge),   32'h0);
    chk({tag, "_valid"}, 32'(frameValid),     32'h0);
    chk({tag, "_contact"}, 32'(contact),      32'h0);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0;
    monkeyDR = 1'b0; monkeyHitEdge = 4'h0; targetDR = 3'b000;
    tick(); tick();
    chk_zero("reset");
    resetN = 1'b1;

    // enter RUN: IDLE -> SYNC -> RUN
    enable = 1'b1;
    step(3'b000, 4'h0, 1'b0);
    step(3'b000, 4'h0, 1'b1);
    chk("sync_no_valid", 32'(frameValid), 32'h0);

    // five overlaps with target 0, one pulse only
    step(3'b001, 4'h8, 1'b0);
    chk("first_pulse", 32'(collisionPulse), 32'h1);
    pulse_sum = 0;
    step(3'b001, 4'h4, 1'b0); pulse_sum += int'(collisionPulse[0]);
    step(3'b001, 4'h8, 1'b0); pulse_sum += int'(collisionPulse[0]);
    step(3'b001, 4'h4, 1'b0); pulse_sum += int'(collisionPulse[0]);
    step(3'b001, 4'h8, 1'b0); pulse_sum += int'(collisionPulse[0]);
    step(3'b000, 4'h0, 1'b0); pulse_sum += int'(collisionPulse[0]);
    chk("extra_pulses", 32'(pulse_sum), 32'h0);
    step(3'b000, 4'h0, 1'b1);
    chk("f1_valid", 32'(frameValid), 32'h1);
    chk("f1_fhe", 32'(frameHitEdge), 32'h00C);
    chk("f1_contact", 32'(contact), 32'h1);
    step(3'b000, 4'h0, 1'b0);
    chk("valid_one_cycle", 32'(frameValid), 32'h0);

    // hysteresis: empty, overlap, empty, empty, empty
    step(3'b000, 4'h0, 1'b1);
    chk("miss1_contact", 32'(contact), 32'h1);
    chk("miss1_fhe", 32'(frameHitEdge), 32'h0);
    step(3'b001, 4'h1, 1'b0);
    chk("reoverlap_pulse", 32'(collisionPulse), 32'h1);
    step(3'b000, 4'h0, 1'b1);
    chk("hit_contact", 32'(contact), 32'h1);
    chk("hit_fhe", 32'(frameHitEdge), 32'h001);
    step(3'b000, 4'h0, 1'b1);
    chk("miss1b_contact", 32'(contact), 32'h1);
    step(3'b000, 4'h0, 1'b1);
    chk("miss2_contact", 32'(contact), 32'h0);
    step(3'b000, 4'h0, 1'b1);
    chk("miss3_contact", 32'(contact), 32'h0);

    // overlap on the startOfFrame cycle belongs to the new frame
    step(3'b010, 4'h1, 1'b0);
    chk("t1_pulse", 32'(collisionPulse), 32'h2);
    step(3'b010, 4'h2, 1'b1);
    chk("sof_pulse", 32'(collisionPulse), 32'h2);
    chk("sof_fhe", 32'(frameHitEdge), 32'h010);
    chk("sof_valid", 32'(frameValid), 32'h1);
    chk("sof_contact", 32'(contact), 32'h2);
    step(3'b010, 4'h4, 1'b0);
    chk("sof_no_repulse", 32'(collisionPulse), 32'h0);
    step(3'b000, 4'h0, 1'b1);
    chk("carry_fhe", 32'(frameHitEdge), 32'h060);
    chk("carry_contact", 32'(contact), 32'h2);

    // targets 0 and 2 in the same cycle
    step(3'b101, 4'h1, 1'b0);
`ifdef COLLISION_PRIORITY_EN
    chk("multi_pulse", 32'(collisionPulse), 32'h1);
`else
    chk("multi_pulse", 32'(collisionPulse), 32'h5);
`endif
    step(3'b000, 4'h0, 1'b1);
`ifdef COLLISION_PRIORITY_EN
    chk("multi_fhe", 32'(frameHitEdge), 32'h001);
    chk("multi_contact", 32'(contact), 32'h3);
`else
    chk("multi_fhe", 32'(frameHitEdge), 32'h101);
    chk("multi_contact", 32'(contact), 32'h7);
`endif

    // asynchronous reset mid-frame with acc=F and contact set
    step(3'b001, 4'hF, 1'b0);
    chk("pre_reset_pulse", 32'(collisionPulse), 32'h1);
    monkeyDR = 1'b0; targetDR = 3'b000; monkeyHitEdge = 4'h0;
    #2 resetN = 1'b0;
    #1 chk_zero("async_reset");
    #1 resetN = 1'b1;
    step(3'b000, 4'h0, 1'b0);
    chk("post_reset_valid_a", 32'(frameValid), 32'h0);
    step(3'b000, 4'h0, 1'b1);
    chk("post_reset_valid_b", 32'(frameValid), 32'h0);
    step(3'b000, 4'h0, 1'b0);
    step(3'b000, 4'h0, 1'b0);
    step(3'b000, 4'h0, 1'b1);
    chk("post_reset_valid_c", 32'(frameValid), 32'h1);
    chk("post_reset_fhe", 32'(frameHitEdge), 32'h0);
    chk("post_reset_contact", 32'(contact), 32'h0);

    // enable drop mid-frame, then restart
    step(3'b010, 4'h3, 1'b0);
    step(3'b000, 4'h0, 1'b1);
    chk("pre_dis_contact", 32'(contact), 32'h2);
    step(3'b010, 4'h3, 1'b0);
    enable = 1'b0;
    step(3'b010, 4'h3, 1'b0);
    chk_zero("disable");
    enable = 1'b1;
    step(3'b010, 4'h3, 1'b0);
    chk("idle_pulse", 32'(collisionPulse), 32'h0);
    step(3'b010, 4'h3, 1'b0);
    chk("sync_pulse", 32'(collisionPulse), 32'h0);
    step(3'b010, 4'h3, 1'b1);
    chk("resync_pulse", 32'(collisionPulse), 32'h2);
    chk("resync_valid", 32'(frameValid), 32'h0);
    chk("resync_contact", 32'(contact), 32'h0);
    step(3'b010, 4'h3, 1'b0);
    chk("resync_no_repulse", 32'(collisionPulse), 32'h0);
    step(3'b000, 4'h0, 1'b1);
    chk("resync_report_valid", 32'(frameValid), 32'h1);
    chk("resync_report_fhe", 32'(frameHitEdge), 32'h030);
    chk("resync_report_contact", 32'(contact), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
